// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, issues word fetches to imem, buffers
// responses in a small prefetch FIFO and hands them to the cu in order.
// Ports: clk/reset; imem_req_* / imem_addr toward memory; imem_rsp_* back;
// instr_valid/instr_ready/instr/instr_pc toward cu; redirect_valid/redirect_pc
// from the branch unit (bits [1:0] of redirect_pc are ignored).
module instr_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] STEP = XLEN'(4);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] fetch_pc, fetch_n;
  logic [XLEN-1:0] rsp_pc, rsp_n;
  logic [CW-1:0]   out_cnt, out_n;
  logic [CW-1:0]   drop_cnt, drop_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [AW-1:0]   rd_ptr, rd_n;
  logic [AW-1:0]   wr_ptr, wr_n;

  logic [XLEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] pc_q   [DEPTH];

  logic            credit;
  logic            req;
  logic            accept;
  logic            rsp_ok;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] target;

  assign target = {redirect_pc[XLEN-1:2], 2'b00};

  // In-flight plus buffered words never exceed the FIFO size, so every
  // response always has a slot waiting for it.
  assign credit = ({1'b0, out_cnt} + {1'b0, cnt}) < DEPTH_C;
  assign req    = (state == RUN) & ~redirect_valid & credit;
  assign accept = req & imem_req_ready;
  // A stray response with nothing outstanding is ignored.
  assign rsp_ok = imem_rsp_valid & (out_cnt != '0);
  assign push   = rsp_ok & (state == RUN) & ~redirect_valid;
  assign pop    = instr_valid & instr_ready;

  assign imem_req_valid = req;
  assign imem_addr      = fetch_pc;
  assign instr_valid    = (cnt != '0);
  assign instr          = data_q[rd_ptr];
  assign instr_pc       = pc_q[rd_ptr];

  always_comb begin
    state_n = state;
    fetch_n = fetch_pc;
    rsp_n   = rsp_pc;
    drop_n  = drop_cnt;
    cnt_n   = cnt;
    rd_n    = rd_ptr;
    wr_n    = wr_ptr;
    out_n   = out_cnt + CW'(accept) - CW'(rsp_ok);

    if (redirect_valid) begin
      // Everything buffered or still in flight belongs to the old path.
      fetch_n = target;
      rsp_n   = target;
      drop_n  = out_n;
      cnt_n   = '0;
      rd_n    = '0;
      wr_n    = '0;
    end else begin
      if (accept) fetch_n = fetch_pc + STEP;
      if (push) begin
        rsp_n = rsp_pc + STEP;
        wr_n  = wr_ptr + AW'(1);
      end
      if (pop) rd_n = rd_ptr + AW'(1);
      cnt_n = cnt + CW'(push) - CW'(pop);
      if (state == DRAIN && rsp_ok && drop_cnt != '0)
        drop_n = drop_cnt - CW'(1);
    end

    unique case (state)
      IDLE:  state_n = RUN;
      RUN:   if (redirect_valid && out_n != '0) state_n = DRAIN;
      DRAIN: if (!redirect_valid && drop_n == '0) state_n = RUN;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      out_cnt  <= '0;
      drop_cnt <= '0;
      cnt      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_n;
      rsp_pc   <= rsp_n;
      out_cnt  <= out_n;
      drop_cnt <= drop_n;
      cnt      <= cnt_n;
      rd_ptr   <= rd_n;
      wr_ptr   <= wr_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      data_q[wr_ptr] <= imem_rsp_data;
      pc_q[wr_ptr]   <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a random phase,
// checked by a program-order scoreboard and a memory address model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        req5_valid;
  logic [31:0] addr5;
  logic        rsp5_valid;
  logic [31:0] rsp5_data;
  logic        iv5;
  logic [31:0] instr5, pc5;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut5 (
    .clk(clk), .reset(reset),
    .imem_req_valid(req5_valid), .imem_req_ready(1'b1),
    .imem_addr(addr5),
    .imem_rsp_valid(rsp5_valid), .imem_rsp_data(rsp5_data),
    .instr_valid(iv5), .instr_ready(1'b1),
    .instr(instr5), .instr_pc(pc5),
    .redirect_valid(1'b0), .redirect_pc(32'h0)
  );

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          acc_total = 0;
  int          last_due = 0;
  int          lat_fix = 1;
  bit          rdy_rand = 0;
  bit          wrap_seen = 0;
  logic [31:0] pa[$];
  int          pd[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_last;
  logic [31:0] nf;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic topup();
    while (exp_q.size() < 8) begin
      exp_last = exp_last + 32'd4;
      exp_q.push_back(exp_last);
    end
  endtask

  task automatic exp_restart(input logic [31:0] p);
    exp_q.delete();
    exp_last = {p[31:2], 2'b00} - 32'd4;
    topup();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    topup();
  endtask

  task automatic redirect(input logic [31:0] p);
    redirect_valid = 1'b1;
    redirect_pc = p;
    exp_restart(p);
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic reset_outputs(input string tag);
    check({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
    check({tag, "_instr_valid"}, {31'b0, instr_valid}, 32'd0);
    check({tag, "_addr"}, imem_addr, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    exp_restart(32'h0);
    repeat (3) step();
    @(negedge clk);
    reset_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Memory response driver: in-order, one per cycle once due.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    imem_req_ready = 1'b1;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      imem_rsp_valid = (pd.size() > 0) && (pd[0] <= cyc);
      imem_rsp_data = imem_rsp_valid ? memf(pa[0]) : $urandom;
      imem_req_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: memory bookkeeping, fetch address model, instruction scoreboard.
  initial begin
    int          due;
    int          lat;
    logic [31:0] e;
    bit          prev_reset;
    nf = 32'h0;
    prev_reset = 1'b1;
    forever begin
      @(negedge clk);
      if (reset) begin
        pa.delete();
        pd.delete();
        last_due = 0;
        nf = 32'h0;
      end else begin
        if (prev_reset)
          assert (!imem_rsp_valid) else $error("response for pre-reset request");
        if (imem_rsp_valid && pa.size() > 0) begin
          void'(pa.pop_front());
          void'(pd.pop_front());
        end
        if (redirect_valid) begin
          check("req_in_redirect", {31'b0, imem_req_valid}, 32'd0);
          nf = {redirect_pc[31:2], 2'b00};
        end else if (imem_req_valid && imem_req_ready) begin
          check("fetch_addr", imem_addr, nf);
          nf = nf + 32'd4;
          acc_total++;
          lat = (lat_fix != 0) ? lat_fix : $urandom_range(1, 3);
          due = cyc + lat;
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          pa.push_back(imem_addr);
          pd.push_back(due);
          check("credit", {31'b0, pa.size() <= 2}, 32'd1);
        end
        if (instr_valid && instr_ready && !redirect_valid) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty got_pc=%h", instr_pc);
          end else begin
            e = exp_q.pop_front();
            check("instr_pc", instr_pc, e);
            check("instr_data", instr, memf(e));
          end
        end
      end
      prev_reset = reset;
    end
  end

  // Second instance: wrap-around at the top of the address space.
  initial begin
    logic [31:0] nf5;
    logic [31:0] a5;
    bit          acc5;
    nf5 = 32'hFFFF_FFF8;
    a5 = 32'h0;
    acc5 = 1'b0;
    rsp5_valid = 1'b0;
    rsp5_data = 32'h0;
    forever begin
      @(negedge clk);
      acc5 = 1'b0;
      if (reset) begin
        nf5 = 32'hFFFF_FFF8;
      end else if (req5_valid) begin
        check("wrap_addr", addr5, nf5);
        if (addr5 == 32'h0) wrap_seen = 1'b1;
        nf5 = nf5 + 32'd4;
        acc5 = 1'b1;
        a5 = addr5;
      end
      @(posedge clk);
      #1;
      rsp5_valid = acc5;
      rsp5_data = a5;
    end
  end

  initial begin
    int k;
    int first;
    reset = 1'b1;
    instr_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    exp_last = 32'h0;

    // 1: free-running fetch, first instruction 3 cycles after release
    lat_fix = 1;
    do_reset();
    first = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) check("idle_no_req", {31'b0, imem_req_valid}, 32'd0);
      if (instr_valid) begin
        first = i;
        break;
      end
    end
    check("first_valid_lat", first, 3);
    repeat (20) step();

    // 2: cu stalled -> only DEPTH requests, then in-order pop
    instr_ready = 1'b0;
    do_reset();
    k = acc_total;
    repeat (10) step();
    @(negedge clk);
    check("stall_req_count", acc_total - k, 32'd2);
    check("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
    @(posedge clk);
    #1;
    instr_ready = 1'b1;
    @(negedge clk);
    check("stall_pop0", instr_pc, 32'h0);
    step();
    @(negedge clk);
    check("stall_pop1", instr_pc, 32'h4);

    // 3: redirect with two fetches in flight
    lat_fix = 4;
    do_reset();
    for (int i = 0; i < 20 && pa.size() != 2; i++) step();
    check("two_outstanding", pa.size(), 32'd2);
    redirect(32'h100);
    first = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        first = i;
        break;
      end
    end
    check("redir_found", {31'b0, first >= 0}, 32'd1);
    check("redir_pc", instr_pc, 32'h100);
    repeat (5) step();

    // 4: redirect to unaligned pc with full FIFO and pop in same cycle
    lat_fix = 1;
    instr_ready = 1'b0;
    repeat (14) step();
    @(negedge clk);
    check("full_valid", {31'b0, instr_valid}, 32'd1);
    check("full_no_req", {31'b0, imem_req_valid}, 32'd0);
    @(posedge clk);
    #1;
    instr_ready = 1'b1;
    redirect(32'h203);
    @(negedge clk);
    check("flush_empty", {31'b0, instr_valid}, 32'd0);
    check("flush_req", {31'b0, imem_req_valid}, 32'd1);
    check("flush_addr", imem_addr, 32'h200);
    repeat (10) step();

    // 6: reset in the middle of a drain
    lat_fix = 4;
    do_reset();
    for (int i = 0; i < 20 && pa.size() != 2; i++) step();
    redirect(32'h40);
    reset = 1'b1;
    exp_restart(32'h0);
    step();
    @(negedge clk);
    reset_outputs("drain_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    first = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req_valid) begin
        first = i;
        break;
      end
    end
    check("restart_cycle", first, 32'd1);
    check("restart_addr", imem_addr, 32'h0);
    repeat (10) step();

    // random phase
    rdy_rand = 1'b1;
    lat_fix = 0;
    for (int i = 0; i < 600; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) redirect($urandom);
      else step();
    end
    rdy_rand = 1'b0;
    instr_ready = 1'b1;
    repeat (20) step();

    check("wrap_seen", {31'b0, wrap_seen}, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
